// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

   typedef enum logic [2:0] {
      Idle,
      Address,
      AddrAck,
      RxByte,
      RxAck,
      TxByte,
      TxAck,
      Ignore
   } state_t;

   localparam logic       Ack         = 1'b0;
   localparam logic       Nack        = 1'b1;
   localparam logic [3:0] BitsPerByte = 4'd8;

   // Bit counter advances on each scl rise and parks at a full byte.
   function automatic logic [3:0] bit_cnt_inc(input logic [3:0] value);
      return (value >= BitsPerByte) ? BitsPerByte : value + 4'd1;
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer and glitch filter for one I2C line, with rise/fall pulses
// derived from the filtered level.
module i2c_line_filter #(
   parameter int FilterLength = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [1:0] sync;
   logic [3:0] count;
   logic       level_q;

   // NOTE: non-blocking assignments make every flop sample its pre-edge input;
   // blocking ones here would collapse the synchronizer into a single stage.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync    <= 2'b11;
         count   <= '0;
         level   <= 1'b1;
         level_q <= 1'b1;
      end else begin
         sync    <= {sync[0], line};
         level_q <= level;
         if (sync[1] == level) begin
            count <= '0;
         end else if (count == 4'(FilterLength - 1)) begin
            level <= sync[1];
            count <= '0;
         end else begin
            count <= count + 4'd1;
         end
      end
   end

   assign rise = level & ~level_q;
   assign fall = ~level & level_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte receive/transmit through strobes.
// Optional scl clock stretching on reads: I2C_TARGET_CLOCK_STRETCH_EN.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] OwnAddress   = 7'h50,
   parameter int         FilterLength = 3
) (
   input  logic       clock,
   input  logic       reset,
   inout  wire        sda,
   inout  wire        scl,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       rxFirst,
   input  logic [7:0] txData,
   input  logic       txValid,
   output logic       txRequest,
   output logic       busy
);

   logic sda_f, sda_rise, sda_fall;
   logic scl_f, scl_rise, scl_fall;

   i2c_line_filter #(.FilterLength(FilterLength)) u_sda_filter (
      .clock(clock), .reset(reset), .line(sda),
      .level(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   i2c_line_filter #(.FilterLength(FilterLength)) u_scl_filter (
      .clock(clock), .reset(reset), .line(scl),
      .level(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;

   state_t     state, state_next;
   logic [3:0] bit_cnt, bit_cnt_next;
   logic [7:0] shift, shift_next, tx_shift, tx_shift_next, rx_data_next;
   logic       rw, rw_next, first, first_next, sda_low, sda_low_next;
   logic       busy_next, rx_valid_next, rx_first_next, tx_request_next, tx_load;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
   logic       scl_low, scl_low_next, stretch, stretch_next;
`endif

   // NOTE: every signal this block writes gets a default first, so no branch
   // can leave one unassigned and infer a latch.
   always_comb begin
      state_next      = state;
      bit_cnt_next    = bit_cnt;
      shift_next      = shift;
      tx_shift_next   = tx_shift;
      rx_data_next    = rxData;
      rw_next         = rw;
      first_next      = first;
      sda_low_next    = sda_low;
      busy_next       = busy;
      rx_valid_next   = 1'b0;
      rx_first_next   = 1'b0;
      tx_request_next = 1'b0;
      tx_load         = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      scl_low_next    = scl_low;
      stretch_next    = stretch;
`endif

      if (scl_rise) begin
         bit_cnt_next = bit_cnt_inc(bit_cnt);
         shift_next   = {shift[6:0], sda_f};
      end

      case (state)
         Address: if (scl_fall && bit_cnt == BitsPerByte) begin
            // General call (0x00) is never acknowledged.
            if (shift[7:1] == OwnAddress && shift[7:1] != 7'h00) begin
               state_next      = AddrAck;
               sda_low_next    = 1'b1;
               busy_next       = 1'b1;
               rw_next         = shift[0];
               tx_request_next = shift[0];
               first_next      = 1'b1;
            end else begin
               state_next = Ignore;
            end
         end
         AddrAck: if (scl_fall) begin
            sda_low_next = 1'b0;
            bit_cnt_next = '0;
            if (rw) tx_load = 1'b1;
            else    state_next = RxByte;
         end
         RxByte: begin
            if (scl_rise && bit_cnt == BitsPerByte - 4'd1) begin
               rx_data_next  = {shift[6:0], sda_f};
               rx_valid_next = 1'b1;
               rx_first_next = first;
               first_next    = 1'b0;
            end
            if (scl_fall && bit_cnt == BitsPerByte) begin
               state_next   = RxAck;
               sda_low_next = 1'b1;
            end
         end
         RxAck: if (scl_fall) begin
            sda_low_next = 1'b0;
            bit_cnt_next = '0;
            state_next   = RxByte;
         end
         TxByte: if (scl_fall) begin
            if (bit_cnt == BitsPerByte) begin
               sda_low_next = 1'b0;
               state_next   = TxAck;
            end else begin
               sda_low_next  = ~tx_shift[6];
               tx_shift_next = {tx_shift[6:0], 1'b0};
            end
         end
         TxAck: begin
            if (scl_rise) begin
               if (sda_f == Ack) tx_request_next = 1'b1;
               else              state_next = Ignore;
            end
            if (scl_fall) begin
               bit_cnt_next = '0;
               tx_load      = 1'b1;
            end
         end
         default: ;
      endcase

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      if (tx_load) begin
         scl_low_next = 1'b1;
         stretch_next = 1'b1;
      end
      if (stretch && txValid) begin
         tx_shift_next = txData;
         sda_low_next  = ~txData[7];
         scl_low_next  = 1'b0;
         stretch_next  = 1'b0;
         state_next    = TxByte;
      end
`else
      if (tx_load) begin
         tx_shift_next = txData;
         sda_low_next  = ~txData[7];
         state_next    = TxByte;
      end
`endif

      // Bus conditions override bit processing; STOP wins over START.
      if (start_det || stop_det) begin
         state_next   = stop_det ? Idle : Address;
         bit_cnt_next = '0;
         busy_next    = 1'b0;
         sda_low_next = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         scl_low_next = 1'b0;
         stretch_next = 1'b0;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= Idle;
         bit_cnt   <= '0;
         shift     <= '0;
         tx_shift  <= '0;
         rw        <= 1'b0;
         first     <= 1'b0;
         sda_low   <= 1'b0;
         rxData    <= '0;
         rxValid   <= 1'b0;
         rxFirst   <= 1'b0;
         txRequest <= 1'b0;
         busy      <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         scl_low   <= 1'b0;
         stretch   <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         shift     <= shift_next;
         tx_shift  <= tx_shift_next;
         rw        <= rw_next;
         first     <= first_next;
         sda_low   <= sda_low_next;
         rxData    <= rx_data_next;
         rxValid   <= rx_valid_next;
         rxFirst   <= rx_first_next;
         txRequest <= tx_request_next;
         busy      <= busy_next;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
         scl_low   <= scl_low_next;
         stretch   <= stretch_next;
`endif
      end
   end

   // Gating with reset releases the lines as soon as reset is asserted.
   assign sda = (sda_low && reset) ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
   assign scl = (scl_low && reset) ? 1'b0 : 1'bz;
`else
   assign scl = 1'bz;
   logic unused_tx_valid;
   assign unused_tx_valid = txValid;
`endif

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged open-drain initiator plus monitors.
module tb_i2c_target;
   import i2c_pkg::*;

   localparam int Q = 12;

   logic       clock = 1'b0;
   logic       reset;
   logic       m_sda_low, m_scl_low;
   wire        sda_bus, scl_bus;
   logic [7:0] rxData, txData;
   logic       rxValid, rxFirst, txRequest, busy, txValid;

   pullup (sda_bus);
   pullup (scl_bus);
   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
   assign scl_bus = m_scl_low ? 1'b0 : 1'bz;

   always #5 clock = ~clock;

   i2c_target #(.OwnAddress(7'h50), .FilterLength(3)) dut (
      .clock(clock), .reset(reset), .sda(sda_bus), .scl(scl_bus),
      .rxData(rxData), .rxValid(rxValid), .rxFirst(rxFirst),
      .txData(txData), .txValid(txValid), .txRequest(txRequest), .busy(busy)
   );

   int         n_cmp = 0, n_err = 0;
   int         tx_req_cnt = 0, overlap_cnt = 0, dut_sda_cnt = 0, dut_scl_cnt = 0;
   int         stretch_max = 0;
   logic [7:0] rx_q[$];
   logic       first_q[$];

   always @(negedge clock) begin
      if (rxValid) begin
         rx_q.push_back(rxData);
         first_q.push_back(rxFirst);
      end
      if (txRequest) tx_req_cnt++;
      if (rxValid && txRequest) overlap_cnt++;
      if (sda_bus === 1'b0 && !m_sda_low) dut_sda_cnt++;
      if (scl_bus === 1'b0 && !m_scl_low) dut_scl_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q;
      repeat (Q) @(posedge clock);
   endtask

   task automatic release_scl;
      int waited;
      waited = 0;
      m_scl_low = 1'b0;
      while (scl_bus !== 1'b1 && waited < 2000) begin
         @(posedge clock);
         waited++;
      end
      if (waited > stretch_max) stretch_max = waited;
      if (waited >= 2000) check("scl_release_timeout", scl_bus, 1'b1);
   endtask

   task automatic bus_start;
      m_sda_low = 1'b0; wait_q;
      release_scl;      wait_q;
      m_sda_low = 1'b1; wait_q;
      m_scl_low = 1'b1; wait_q;
   endtask

   task automatic bus_stop;
      m_sda_low = 1'b1; wait_q;
      release_scl;      wait_q;
      m_sda_low = 1'b0; wait_q; wait_q;
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      m_sda_low = ~b; wait_q;
      release_scl;    wait_q;
      if (glitch) begin
         m_sda_low = b;
         repeat (2) @(posedge clock);
         m_sda_low = ~b;
      end
      wait_q;
      m_scl_low = 1'b1; wait_q;
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; wait_q;
      release_scl;      wait_q;
      b = sda_bus;      wait_q;
      m_scl_low = 1'b1; wait_q;
   endtask

   task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic [7:0] next_tx, input logic ack, output logic [7:0] d);
      logic b;
      d = '0;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      txData = next_tx;
      send_bit(ack, 1'b0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic [7:0] d;
      int         base;

      reset = 1'b0; m_sda_low = 1'b0; m_scl_low = 1'b0; txData = 8'h00; txValid = 1'b1;
      repeat (5) @(posedge clock);
      @(negedge clock);
      check("rst_rxData", rxData, 8'h00);
      check("rst_rxValid", rxValid, 1'b0);
      check("rst_rxFirst", rxFirst, 1'b0);
      check("rst_txRequest", txRequest, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sda", sda_bus, 1'b1);
      check("rst_scl", scl_bus, 1'b1);
      check("rst_state", dut.state, Idle);
      check("rst_bit_cnt", dut.bit_cnt, 4'd0);
      reset = 1'b1;
      repeat (10) @(posedge clock);

      // Write 0x50: A5, 3C
      bus_start;
      write_byte(8'hA0, 8'h00, ack); check("w_addr_ack", ack, Ack);
      check("w_busy", busy, 1'b1);
      write_byte(8'hA5, 8'h00, ack); check("w_b0_ack", ack, Ack);
      write_byte(8'h3C, 8'h00, ack); check("w_b1_ack", ack, Ack);
      bus_stop;
      check("w_rx_count", rx_q.size(), 2);
      check("w_rx0", rx_q[0], 8'hA5);
      check("w_first0", first_q[0], 1'b1);
      check("w_rx1", rx_q[1], 8'h3C);
      check("w_first1", first_q[1], 1'b0);
      check("w_busy_stop", busy, 1'b0);
      check("w_state_stop", dut.state, Idle);

      // Write 0x51: ignored
      base = dut_sda_cnt;
      bus_start;
      write_byte(8'hA2, 8'h00, ack); check("o_addr_nack", ack, Nack);
      check("o_state", dut.state, Ignore);
      write_byte(8'h55, 8'h00, ack); check("o_b0_nack", ack, Nack);
      check("o_state2", dut.state, Ignore);
      check("o_busy", busy, 1'b0);
      bus_stop;
      check("o_sda_driven", dut_sda_cnt - base, 0);
      check("o_rx_count", rx_q.size(), 2);
      check("o_state_stop", dut.state, Idle);

      // Read 0x50: C3 (ACK), 81 (NACK)
      base = tx_req_cnt;
      txData = 8'hC3;
      bus_start;
      write_byte(8'hA1, 8'h00, ack); check("r_addr_ack", ack, Ack);
      check("r_busy", busy, 1'b1);
      check("r_req1", tx_req_cnt - base, 1);
      read_byte(8'h81, Ack, d);  check("r_byte0", d, 8'hC3);
      check("r_req2", tx_req_cnt - base, 2);
      read_byte(8'h00, Nack, d); check("r_byte1", d, 8'h81);
      check("r_req_after_nack", tx_req_cnt - base, 2);
      check("r_state_nack", dut.state, Ignore);
      check("r_sda_released", sda_bus, 1'b1);
      bus_stop;
      check("r_rx_count", rx_q.size(), 2);

      // Write 10, repeated START, read one byte
      bus_start;
      write_byte(8'hA0, 8'h00, ack); check("rs_waddr_ack", ack, Ack);
      write_byte(8'h10, 8'h00, ack); check("rs_wbyte_ack", ack, Ack);
      check("rs_rx_count", rx_q.size(), 3);
      check("rs_rx", rx_q[2], 8'h10);
      check("rs_first", first_q[2], 1'b1);
      txData = 8'h5A;
      bus_start;
      check("rs_busy_drop", busy, 1'b0);
      check("rs_state_addr", dut.state, Address);
      write_byte(8'hA1, 8'h00, ack); check("rs_raddr_ack", ack, Ack);
      check("rs_busy_rise", busy, 1'b1);
      read_byte(8'h00, Nack, d); check("rs_rbyte", d, 8'h5A);
      bus_stop;
      check("rs_rx_count2", rx_q.size(), 3);

      // Reset in the middle of TxByte
      txData = 8'h00;
      bus_start;
      write_byte(8'hA1, 8'h00, ack); check("mr_addr_ack", ack, Ack);
      for (int i = 0; i < 3; i++) read_bit(ack);
      check("mr_sda_driving", sda_bus, 1'b0);
      @(posedge clock);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("mr_sda", sda_bus, 1'b1);
      check("mr_busy", busy, 1'b0);
      check("mr_rxData", rxData, 8'h00);
      check("mr_rxValid", rxValid, 1'b0);
      check("mr_rxFirst", rxFirst, 1'b0);
      check("mr_txRequest", txRequest, 1'b0);
      check("mr_state", dut.state, Idle);
      repeat (3) @(posedge clock);
      reset = 1'b1;
      bus_stop;
      bus_start;
      write_byte(8'hA0, 8'h00, ack); check("mr_next_addr_ack", ack, Ack);
      write_byte(8'h77, 8'h00, ack); check("mr_next_ack", ack, Ack);
      bus_stop;
      check("mr_rx_count", rx_q.size(), 4);
      check("mr_rx", rx_q[3], 8'h77);
      check("mr_first", first_q[3], 1'b1);

      // 2-cycle glitches are filtered out
      m_sda_low = 1'b1;
      repeat (2) @(posedge clock);
      m_sda_low = 1'b0;
      repeat (20) @(posedge clock);
      check("g_idle_state", dut.state, Idle);
      bus_start;
      write_byte(8'hA0, 8'hC0, ack); check("g_addr_ack", ack, Ack);
      write_byte(8'h96, 8'hFF, ack); check("g_byte_ack", ack, Ack);
      check("g_busy", busy, 1'b1);
      bus_stop;
      check("g_rx_count", rx_q.size(), 5);
      check("g_rx", rx_q[4], 8'h96);
      check("g_first", first_q[4], 1'b1);
      check("overlap", overlap_cnt, 0);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      // Read with txValid delayed 50 cycles: scl is held low meanwhile
      txValid = 1'b0;
      txData  = 8'hE7;
      bus_start;
      write_byte(8'hA1, 8'h00, ack); check("s_addr_ack", ack, Ack);
      stretch_max = 0;
      fork
         read_byte(8'h00, Nack, d);
         begin
            repeat (50) @(posedge clock);
            txValid = 1'b1;
         end
      join
      check("s_byte", d, 8'hE7);
      check("s_stretch_len", (stretch_max >= 35 && stretch_max <= 43), 1'b1);
      bus_stop;
      check("s_scl_released", scl_bus, 1'b1);
`else
      check("no_scl_drive", dut_scl_cnt, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder: the far end of the existing I2C master; lets the FPGA answer a bus initiator.
- Sampling is oversampled from the system clock; no logic runs in the SCL domain.
- Detects START/STOP, matches a 7-bit own address, ACKs it, delivers written bytes and serves read bytes through a byte handshake.
- Drives sda/scl open-drain: drives 0 or releases to 'z.

Parameters:
- OwnAddress, 7'h50, 7-bit address the block answers to.
- FilterLength, 3, consecutive equal samples required before a filtered line changes (range 1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset; synchronous, active-low.
- sda  inout  1  I2C data; open-drain (0 or 'z).
- scl  inout  1  I2C clock; open-drain; only ever driven 0 under the optional feature, otherwise always 'z.
- rxData  out  8  last byte written by the initiator.
- rxValid  out  1  one-cycle strobe; rxData is new.
- rxFirst  out  1  qualifies rxValid; set for the first data byte after the address.
- txData  in  8  next byte to return on a read.
- txValid  in  1  txData ready; used only with the optional feature, ignored otherwise.
- txRequest  out  1  one-cycle strobe; the block needs the next read byte.
- busy  out  1  high from own-address ACK until STOP or repeated START.

Behaviour:
- Reset (reset=0 at clock edge):
  - sda and scl released ('z); rxData=0, rxValid=0, rxFirst=0, txRequest=0, busy=0.
  - State=Idle, bit counter=0.
  - Reset mid-transaction releases the lines in the same cycle.
- Input path, per line:
  - 2-flop synchronizer, then a glitch filter that changes the filtered value only after FilterLength consecutive equal samples.
  - Rise and fall pulses are generated from the filtered value.
- Bus events on filtered signals:
  - START: sda falls while scl high. STOP: sda rises while scl high.
  - Data is sampled on scl rise; sda output changes only in the cycle after a detected scl fall.
- State machine:
  - Idle: wait for START, then go to Address.
  - Address: shift 8 bits MSB first (bit counter 0..7), then compare.
    - Upper 7 bits equal OwnAddress: go to AddrAck.
    - Otherwise: go to Ignore; no ACK.
    - Address 0x00 (general call) is NACKed.
  - AddrAck:
    - After the 8th scl fall, drive sda=0; release at the 9th scl fall.
    - Set busy.
    - R/W=0: go to RxByte.
    - R/W=1: pulse txRequest in the cycle after the 8th scl fall, latch txData at the 9th scl fall, go to TxByte.
  - RxByte: shift 8 bits; in the cycle after the 8th rise, load rxData and pulse rxValid (rxFirst=1 only for the first byte); go to RxAck.
  - RxAck: ACK exactly as in AddrAck; return to RxByte. Every written byte is ACKed.
  - TxByte: present bits MSB first; each bit is driven after the previous scl fall (bit 7 after the ACK fall); release sda after the 8th fall; go to TxAck.
  - TxAck: sample sda on the 9th rise.
    - 0 (ACK): pulse txRequest, latch txData at the 9th fall, go to TxByte.
    - 1 (NACK): go to Ignore.
  - Ignore: sda released; wait for a bus event.
- Priority and boundaries:
  - STOP in any state: go to Idle, busy=0, sda released. This takes priority over bit processing in the same cycle.
  - START in any state, including a repeated START mid-byte: clear the bit counter, go to Address, busy=0.
  - rxValid and txRequest never assert in the same cycle.
  - The bit counter saturates at 8 and is cleared on each ACK-phase scl fall.
  - Without the optional feature, txData must be stable by the 9th scl fall. The consumer has at least half an SCL period after txRequest.

Optional Feature:
- Macro: I2C_TARGET_CLOCK_STRETCH_EN.
- Defined:
  - After the 9th scl fall of a read-address ACK or a master ACK, hold scl=0 until txValid=1.
  - txData is latched on that cycle and scl is released in the next cycle.
  - A STOP or reset releases scl immediately.
- Undefined:
  - scl is never driven; txValid is ignored; txData is latched at the 9th scl fall regardless.

Decomposition:
- Package i2c_pkg:
  - typedef enum state_t {Idle, Address, AddrAck, RxByte, RxAck, TxByte, TxAck, Ignore}.
  - Localparams Ack=1'b0, Nack=1'b1, BitsPerByte=8.
- One sub-module, i2c_line_filter (synchronizer, glitch filter, rise/fall pulses), instantiated once for sda and once for scl.

Test Plan:
- Write to 0x50, bytes 0xA5, 0x3C, then STOP: three ACKs; rxValid twice with rxData 0xA5 (rxFirst=1) then 0x3C (rxFirst=0); busy falls at STOP.
- Write to 0x51: sda never driven; no rxValid; state Ignore until STOP.
- Read from 0x50 with txData 0xC3 then 0x81, master ACK then NACK: bus shows 0xC3, 0x81; txRequest twice; sda released after NACK.
- Write 0x50 byte 0x10, repeated START, read 0x50 one byte: rxValid once with 0x10; busy drops at repeated START and rises at the read-address ACK; read byte is correct.
- Reset asserted low mid-bit during TxByte: sda/scl 'z and all outputs 0 in the next cycle; the next transaction works normally.
- 2-cycle sda glitch while scl high (FilterLength=3): no START/STOP detected. With I2C_TARGET_CLOCK_STRETCH_EN and txValid delayed 50 cycles: scl held low for 50 cycles, then the correct byte is sent.
